input_req_ctrl: RTL

//  Input-side requester for one router input port; the counterpart to the per-output mux controllers.

---
 rtl/input_req_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/input_req_ctrl.sv
// Router input-port requester: flit FIFO, XY route of the head flit, wormhole request/grant handshake.
// Optional build macro FWDAB_EN: honour the abs bit (forward-and-absorb also requests local port 0).
module input_req_ctrl #(
    parameter int X_ID    = 0,
    parameter int Y_ID    = 0,
    parameter int COORD_W = 2,
    parameter int FLIT_W  = 34,
    parameter int DEPTH   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [FLIT_W-1:0] in_flit_i,
    output logic              in_ready_o,
    output logic [2:0]        port_o,
    output logic              req_o,
    output logic              fwdab_o,
    input  logic [4:0]        grt_i,
    output logic              out_valid_o,
    output logic [FLIT_W-1:0] out_flit_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int DX_HI = FLIT_W - 4;
    localparam int DY_HI = FLIT_W - 4 - COORD_W;

    localparam logic [AW:0]        DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [COORD_W-1:0] X_C     = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] Y_C     = COORD_W'(Y_ID);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ROUTE  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    localparam logic [2:0] P_L = 3'd0;
    localparam logic [2:0] P_N = 3'd1;
    localparam logic [2:0] P_E = 3'd2;
    localparam logic [2:0] P_S = 3'd3;
    localparam logic [2:0] P_W = 3'd4;

    logic [FLIT_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q, count_d;
    logic [1:0]         state_q, state_d;
    logic [2:0]         port_q, port_d;
    logic               req_q, req_d;
    logic               fwdab_q, fwdab_d;
    logic [7:0]         err_cnt_q, err_cnt_d;

    logic [1:0]         head_type_s;
    logic [COORD_W-1:0] head_dx_s, head_dy_s;
    logic               nonempty_s, is_head_s, is_tail_s;
    logic               push_s, pop_s, drop_s, grant_ok_s;
    logic [2:0]         route_port_s;
`ifdef FWDAB_EN
    logic               head_abs_s;
    assign head_abs_s = out_flit_o[FLIT_W-3];
`endif

    assign out_flit_o  = mem_q[rd_ptr_q];
    assign head_type_s = out_flit_o[FLIT_W-1 -: 2];
    assign head_dx_s   = out_flit_o[DX_HI -: COORD_W];
    assign head_dy_s   = out_flit_o[DY_HI -: COORD_W];
    assign is_head_s   = head_type_s[0];
    assign is_tail_s   = head_type_s[1];
    assign nonempty_s  = (count_q != {(AW + 1){1'b0}});

    assign in_ready_o  = (count_q != DEPTH_C);
    assign port_o      = port_q;
    assign req_o       = req_q;
    assign fwdab_o     = fwdab_q;

`ifdef FWDAB_EN
    assign grant_ok_s  = grt_i[port_q] & (~fwdab_q | grt_i[0]);
`else
    assign grant_ok_s  = grt_i[port_q];
`endif

    assign out_valid_o = (state_q == S_ACTIVE) & nonempty_s & grant_ok_s;
    // Stray body/tail flits at the head while idle are discarded without a transfer.
    assign drop_s      = (state_q == S_IDLE) & nonempty_s & ~is_head_s;
    assign pop_s       = out_valid_o | drop_s;
    assign push_s      = in_valid_i & in_ready_o;

    // XY routing: resolve X first, then Y.
    always_comb begin
        route_port_s = P_L;
        if (head_dx_s > X_C) begin
            route_port_s = P_E;
        end else if (head_dx_s < X_C) begin
            route_port_s = P_W;
        end else if (head_dy_s > Y_C) begin
            route_port_s = P_S;
        end else if (head_dy_s < Y_C) begin
            route_port_s = P_N;
        end else begin
            route_port_s = P_L;
        end
    end

    // FIFO occupancy next state.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Packet FSM and request/route latches.
    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        req_d     = req_q;
        fwdab_d   = fwdab_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (nonempty_s & is_head_s) begin
                    state_d = S_ROUTE;
                end else begin
                    state_d = S_IDLE;
                end
                if (drop_s && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end else begin
                    err_cnt_d = err_cnt_q;
                end
            end
            S_ROUTE: begin
                state_d = S_ACTIVE;
                port_d  = route_port_s;
                req_d   = 1'b1;
`ifdef FWDAB_EN
                fwdab_d = head_abs_s & (route_port_s != P_L);
`else
                fwdab_d = 1'b0;
`endif
            end
            S_ACTIVE: begin
                if (out_valid_o & is_tail_s) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {(AW + 1){1'b0}};
            state_q   <= S_IDLE;
            port_q    <= P_L;
            req_q     <= 1'b0;
            fwdab_q   <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q   <= count_d;
            state_q   <= state_d;
            port_q    <= port_d;
            req_q     <= req_d;
            fwdab_q   <= fwdab_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Flit storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_flit_i;
        end
    end

endmodule
